// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter_ctrl push-button sequencer: FSM state encoding
// and the debounce counter width.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int DEB_CNT_W = 24;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, optional debounce, rising-edge event.
// Debounce is built only when COUNTER_CTRL_DEBOUNCE_EN is defined; otherwise deb follows sync.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << DEB_CNT_W) - 1) begin : g_bad_cycles
    $error("btn_debounce: DEBOUNCE_CYCLES out of range");
  end

  logic meta;
  logic sync;
  logic deb;
  logic deb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

`ifdef COUNTER_CTRL_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_CNT_W-1:0] cnt;

  // Any sample that agrees with the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign deb = sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deb_q <= 1'b0;
    else      deb_q <= deb;
  end

  // Both terms are flops, so the event is glitch-free; releases produce nothing.
  assign evt = deb & ~deb_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause sequencer between the board buttons and counter_top.
// Debounce enabled by defining COUNTER_CTRL_DEBOUNCE_EN (see btn_debounce).
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | counter stopped, waiting for start
//   RUN   | counter running
//   PAUSE | counter halted, value held, start resumes
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_rst,
  input  logic       btn_tgl,
  output logic       cnt_start,
  output logic       cnt_stop,
  output logic       cnt_rst,
  output logic       disp_tgl,
  output logic [1:0] state
);

  logic ev_start;
  logic ev_stop;
  logic ev_rst;
  logic ev_tgl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .btn(btn_start), .evt(ev_start)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_stop (
    .clk(clk), .rst(rst), .btn(btn_stop), .evt(ev_stop)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
    .clk(clk), .rst(rst), .btn(btn_rst), .evt(ev_rst)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_tgl (
    .clk(clk), .rst(rst), .btn(btn_tgl), .evt(ev_tgl)
  );

  state_t state_q;

  // Event priority within a cycle: rst > stop > start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_start <= 1'b0;
      cnt_stop  <= 1'b0;
      cnt_rst   <= 1'b0;
    end else begin
      cnt_start <= 1'b0;
      cnt_stop  <= 1'b0;
      cnt_rst   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_rst) begin
            cnt_rst <= 1'b1;
          end else if (ev_start) begin
            state_q   <= RUN;
            cnt_start <= 1'b1;
          end
        end
        RUN: begin
          if (ev_rst) begin
            state_q  <= IDLE;
            cnt_stop <= 1'b1;
            cnt_rst  <= 1'b1;
          end else if (ev_stop) begin
            state_q  <= PAUSE;
            cnt_stop <= 1'b1;
          end
        end
        PAUSE: begin
          if (ev_rst) begin
            state_q <= IDLE;
            cnt_rst <= 1'b1;
          end else if (ev_start) begin
            state_q   <= RUN;
            cnt_start <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        disp_tgl <= 1'b0;
    else if (ev_tgl) disp_tgl <= ~disp_tgl;
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl; expected latency follows COUNTER_CTRL_DEBOUNCE_EN.
module tb_counter_ctrl;

  localparam int DEB = 4;
`ifdef COUNTER_CTRL_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btns = 4'b0000;   // {tgl, rst, stop, start}
  logic       cnt_start, cnt_stop, cnt_rst, disp_tgl;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int n_start = 0, n_stop = 0, n_rst = 0;

  counter_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btns[0]), .btn_stop(btns[1]), .btn_rst(btns[2]), .btn_tgl(btns[3]),
    .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_rst(cnt_rst),
    .disp_tgl(disp_tgl), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      n_start += int'(cnt_start);
      n_stop  += int'(cnt_stop);
      n_rst   += int'(cnt_rst);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press, check the pulse window around the expected latency, then release and settle.
  task automatic press_check(input string tag, input logic [3:0] mask, input int hold,
                             input logic [2:0] exp_p, input logic [1:0] exp_st,
                             input logic exp_t);
    btns = mask;
    step(LAT - 1);
    chk({tag, "_pre"}, {29'b0, cnt_start, cnt_stop, cnt_rst}, 32'd0);
    step(1);
    chk({tag, "_pulse"}, {29'b0, cnt_start, cnt_stop, cnt_rst}, {29'b0, exp_p});
    chk({tag, "_state"}, {30'b0, state}, {30'b0, exp_st});
    chk({tag, "_disp"}, {31'b0, disp_tgl}, {31'b0, exp_t});
    step(1);
    chk({tag, "_post"}, {29'b0, cnt_start, cnt_stop, cnt_rst}, 32'd0);
    step(hold - LAT - 1);
    btns = 4'b0000;
    step(LAT + 2);
  endtask

  initial begin
    step(3);
    chk("reset_pulses", {29'b0, cnt_start, cnt_stop, cnt_rst}, 32'd0);
    chk("reset_disp", {31'b0, disp_tgl}, 32'd0);
    chk("reset_state", {30'b0, state}, 32'd0);
    rst = 1'b1;
    step(2);

    press_check("start_idle", 4'b0001, 10, 3'b100, 2'b01, 1'b0);
    chk("start_count", n_start, 1);

`ifdef COUNTER_CTRL_DEBOUNCE_EN
    btns = 4'b0010;
    step(3);
    btns = 4'b0000;
    step(LAT + 3);
    chk("glitch_nstop", n_stop, 0);
    chk("glitch_state", {30'b0, state}, 32'd1);
`endif

    press_check("stop_run", 4'b0010, 20, 3'b010, 2'b10, 1'b0);
    chk("stop_count", n_stop, 1);

    press_check("both_pause", 4'b0011, 10, 3'b100, 2'b01, 1'b0);
    chk("both_nstop", n_stop, 1);
    chk("both_nstart", n_start, 2);

    press_check("rst_run", 4'b0100, 10, 3'b011, 2'b00, 1'b0);
    press_check("stop_idle", 4'b0010, 10, 3'b000, 2'b00, 1'b0);
    chk("stop_idle_count", n_stop, 2);
    press_check("rst_idle", 4'b0100, 10, 3'b001, 2'b00, 1'b0);
    chk("rst_count", n_rst, 2);

    press_check("tgl1", 4'b1000, 10, 3'b000, 2'b00, 1'b1);
    press_check("tgl2", 4'b1000, 10, 3'b000, 2'b00, 1'b0);
    press_check("tgl3", 4'b1000, 10, 3'b000, 2'b00, 1'b1);

    press_check("start_again", 4'b0001, 10, 3'b100, 2'b01, 1'b1);

    btns = 4'b0010;
    step(1);
    rst = 1'b0;
    #1;
    chk("midreset_outs", {27'b0, cnt_start, cnt_stop, cnt_rst, disp_tgl, state}, 32'd0);
    btns = 4'b0000;
    step(3);
    rst = 1'b1;
    step(LAT + 5);
    chk("midreset_state", {30'b0, state}, 32'd0);
    chk("midreset_nstop", n_stop, 2);
    chk("midreset_disp", {31'b0, disp_tgl}, 32'd0);
    chk("final_nstart", n_start, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
